// File: rtl/pixel_fetch_responder_if.sv
// Pixel request/response and memory read-master signals of pixel_fetch_responder.
// slave = responder view, master = core + memory view.
interface pixel_fetch_responder_if;
    logic        en;
    logic        frame_start;
    logic [9:0]  req_x;
    logic [9:0]  req_y;
    logic        waitrequest;
    logic [7:0]  pixel;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [15:0] miss_count;

    modport slave (
        input  en, frame_start, req_x, req_y,
        input  mem_waitrequest, mem_readdata, mem_readdatavalid,
        output waitrequest, pixel, mem_address, mem_read, miss_count
    );

    modport master (
        output en, frame_start, req_x, req_y,
        output mem_waitrequest, mem_readdata, mem_readdatavalid,
        input  waitrequest, pixel, mem_address, mem_read, miss_count
    );
endinterface

// File: rtl/pixel_fetch_responder.sv
// One-word pixel cache between an edge core and a pipelined memory read master.
// Hits and out-of-frame requests answer combinationally; misses do a single word fetch.
module pixel_fetch_responder #(
    parameter int          COL_NUM   = 640,
    parameter int          ROW_NUM   = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input logic                     clk,
    input logic                     rst,
    pixel_fetch_responder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_e;

    state_e      state_q, state_d;
    logic [29:0] tag_q, tag_d;
    logic [29:0] ftag_q, ftag_d;
    logic        valid_q, valid_d;
    logic        drop_q, drop_d;
    logic [31:0] data_q, data_d;
    logic [15:0] miss_q, miss_d;

    logic [31:0] addr;
    logic        in_range;
    logic        hit;
    logic        start;
    logic        ret;

    assign addr     = BASE_ADDR + 32'(bus.req_y) * 32'(COL_NUM) + 32'(bus.req_x);
    assign in_range = (32'(bus.req_x) < 32'(COL_NUM)) && (32'(bus.req_y) < 32'(ROW_NUM));
    assign hit      = valid_q && (tag_q == addr[31:2]);
    // frame_start holds off a new fetch; the request is re-evaluated against the cleared cache next cycle
    assign start    = (state_q == IDLE) && bus.en && in_range && !hit && !bus.frame_start;
    assign ret      = (state_q == WAIT_DATA) && bus.mem_readdatavalid;

    assign bus.mem_read    = !rst && (state_q == ISSUE);
    assign bus.mem_address = rst ? 32'h0 : {ftag_q, 2'b00};
    assign bus.miss_count  = miss_q;

    always_comb begin
        bus.waitrequest = 1'b1;
        bus.pixel       = 8'h00;
        if (rst || !bus.en || state_q != IDLE) begin
            bus.waitrequest = 1'b1;
        end else if (!in_range) begin
            bus.waitrequest = 1'b0;
        end else if (hit) begin
            bus.waitrequest = 1'b0;
            bus.pixel       = 8'(data_q >> {addr[1:0], 3'b000});
        end
    end

    always_comb begin
        state_d = state_q;
        tag_d   = tag_q;
        ftag_d  = ftag_q;
        valid_d = valid_q;
        drop_d  = drop_q;
        data_d  = data_q;
        miss_d  = miss_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    ftag_d  = addr[31:2];
                    miss_d  = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
                end
            end
            ISSUE: begin
                if (!bus.mem_waitrequest) state_d = WAIT_DATA;
            end
            WAIT_DATA: begin
                if (bus.mem_readdatavalid) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                    if (!drop_q) begin
                        data_d  = bus.mem_readdata;
                        tag_d   = ftag_q;
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // A word in flight across a frame boundary belongs to the old frame
        if (bus.frame_start) begin
            valid_d = 1'b0;
            miss_d  = 16'h0;
            if (state_q != IDLE && !ret) drop_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            tag_q   <= '0;
            ftag_q  <= '0;
            valid_q <= 1'b0;
            drop_q  <= 1'b0;
            data_q  <= '0;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            tag_q   <= tag_d;
            ftag_q  <= ftag_d;
            valid_q <= valid_d;
            drop_q  <= drop_d;
            data_q  <= data_d;
            miss_q  <= miss_d;
        end
    end
endmodule

// File: tb/tb_pixel_fetch_responder.sv
// Directed bench for pixel_fetch_responder: hits, misses, borders, backpressure,
// frame_start drops and reset mid-fetch, with hand-computed expectations.
module tb_pixel_fetch_responder;
    localparam logic [31:0] BASE = 32'h0001_0000;

    logic clk;
    logic rst;
    int   errs;
    int   checks;

    pixel_fetch_responder_if bus ();

    pixel_fetch_responder #(
        .COL_NUM  (640),
        .ROW_NUM  (480),
        .BASE_ADDR(BASE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for the read, hold it off for `stall` cycles, accept it, return `data`
    // `lat` cycles after acceptance. fs=1: frame_start during the wait, fs=2: with the data.
    task automatic serve(input string tag, input logic [31:0] exp_addr, input logic [31:0] data,
                         input int stall, input int lat, input int fs);
        int n;
        n = 0;
        while (bus.mem_read !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_rd"}, 32'(bus.mem_read), 32'd1);
        chk({tag, "_addr"}, bus.mem_address, exp_addr);
        bus.mem_waitrequest = (stall > 0);
        for (int i = 0; i < stall; i++) begin
            tick();
            chk({tag, "_stall_rd"}, 32'(bus.mem_read), 32'd1);
            chk({tag, "_stall_addr"}, bus.mem_address, exp_addr);
            chk({tag, "_stall_wr"}, 32'(bus.waitrequest), 32'd1);
        end
        bus.mem_waitrequest = 1'b0;
        tick();
        chk({tag, "_acc_rd"}, 32'(bus.mem_read), 32'd0);
        chk({tag, "_acc_wr"}, 32'(bus.waitrequest), 32'd1);
        for (int i = 1; i < lat; i++) begin
            if (fs == 1 && i == 1) bus.frame_start = 1'b1;
            tick();
            bus.frame_start = 1'b0;
            chk({tag, "_lat_wr"}, 32'(bus.waitrequest), 32'd1);
        end
        bus.mem_readdata      = data;
        bus.mem_readdatavalid = 1'b1;
        if (fs == 2) bus.frame_start = 1'b1;
        tick();
        bus.mem_readdatavalid = 1'b0;
        bus.mem_readdata      = 32'h0;
        bus.frame_start       = 1'b0;
        settle();
    endtask

    task automatic set_req(input logic [9:0] x, input logic [9:0] y);
        bus.req_x = x;
        bus.req_y = y;
        settle();
    endtask

    initial begin
        errs   = 0;
        checks = 0;
        rst    = 1'b1;
        bus.en = 1'b0;
        bus.frame_start       = 1'b0;
        bus.req_x             = '0;
        bus.req_y             = '0;
        bus.mem_waitrequest   = 1'b0;
        bus.mem_readdata      = '0;
        bus.mem_readdatavalid = 1'b0;
        tick();
        tick();
        chk("rst_wr", 32'(bus.waitrequest), 32'd1);
        chk("rst_pix", 32'(bus.pixel), 32'd0);
        chk("rst_rd", 32'(bus.mem_read), 32'd0);
        chk("rst_addr", bus.mem_address, 32'd0);
        chk("rst_miss", 32'(bus.miss_count), 32'd0);
        bus.en = 1'b1;
        settle();
        chk("rst_en_wr", 32'(bus.waitrequest), 32'd1);
        bus.en = 1'b0;
        rst = 1'b0;

        // miss then hits in the same word
        bus.en = 1'b1;
        set_req(10'd0, 10'd0);
        chk("m1_wr", 32'(bus.waitrequest), 32'd1);
        serve("m1", BASE, 32'h4433_2211, 0, 2, 0);
        chk("m1_wr_fill", 32'(bus.waitrequest), 32'd0);
        chk("m1_pix", 32'(bus.pixel), 32'h11);
        set_req(10'd3, 10'd0);
        chk("h3_wr", 32'(bus.waitrequest), 32'd0);
        chk("h3_pix", 32'(bus.pixel), 32'h44);
        set_req(10'd1, 10'd0);
        chk("h1_pix", 32'(bus.pixel), 32'h22);
        chk("h_miss", 32'(bus.miss_count), 32'd1);
        bus.en = 1'b0;
        settle();
        chk("dis_wr", 32'(bus.waitrequest), 32'd1);
        chk("dis_pix", 32'(bus.pixel), 32'd0);
        tick();
        chk("dis_rd", 32'(bus.mem_read), 32'd0);
        bus.en = 1'b1;

        // row crossing
        set_req(10'd639, 10'd0);
        serve("row0", BASE + 32'd636, 32'hD4C3_B2A1, 0, 2, 0);
        chk("row0_pix", 32'(bus.pixel), 32'hD4);
        set_req(10'd0, 10'd1);
        serve("row1", BASE + 32'd640, 32'h8877_6655, 0, 1, 0);
        chk("row1_pix", 32'(bus.pixel), 32'h55);
        chk("row_miss", 32'(bus.miss_count), 32'd3);

        // out-of-frame requests
        set_req(10'd640, 10'd5);
        chk("bx_wr", 32'(bus.waitrequest), 32'd0);
        chk("bx_pix", 32'(bus.pixel), 32'd0);
        tick();
        chk("bx_rd", 32'(bus.mem_read), 32'd0);
        set_req(10'd10, 10'd480);
        chk("by_wr", 32'(bus.waitrequest), 32'd0);
        chk("by_pix", 32'(bus.pixel), 32'd0);
        tick();
        tick();
        chk("by_rd", 32'(bus.mem_read), 32'd0);
        chk("b_miss", 32'(bus.miss_count), 32'd3);

        // memory backpressure
        set_req(10'd100, 10'd2);
        serve("bp", BASE + 32'd1380, 32'hCAFE_BABE, 5, 3, 0);
        chk("bp_wr", 32'(bus.waitrequest), 32'd0);
        chk("bp_pix", 32'(bus.pixel), 32'hBE);
        chk("bp_miss", 32'(bus.miss_count), 32'd4);

        // frame_start while waiting for data: word dropped, refetched
        set_req(10'd5, 10'd3);
        serve("fs1", BASE + 32'd1924, 32'h0000_5500, 0, 3, 1);
        chk("fs1_wr", 32'(bus.waitrequest), 32'd1);
        chk("fs1_miss0", 32'(bus.miss_count), 32'd0);
        serve("fs1r", BASE + 32'd1924, 32'h0000_AB00, 0, 2, 0);
        chk("fs1r_pix", 32'(bus.pixel), 32'hAB);
        chk("fs1r_miss", 32'(bus.miss_count), 32'd1);

        // frame_start in the same cycle as the data
        set_req(10'd8, 10'd3);
        serve("fs2", BASE + 32'd1928, 32'h0000_00EE, 0, 2, 2);
        chk("fs2_wr", 32'(bus.waitrequest), 32'd1);
        chk("fs2_miss0", 32'(bus.miss_count), 32'd0);
        serve("fs2r", BASE + 32'd1928, 32'h0000_00F1, 0, 2, 0);
        chk("fs2r_pix", 32'(bus.pixel), 32'hF1);
        chk("fs2r_miss", 32'(bus.miss_count), 32'd1);

        // reset while waiting for data, stale return afterwards
        set_req(10'd12, 10'd3);
        tick();
        chk("rs_rd", 32'(bus.mem_read), 32'd1);
        tick();
        chk("rs_wait_rd", 32'(bus.mem_read), 32'd0);
        rst    = 1'b1;
        bus.en = 1'b0;
        settle();
        chk("rs_hold_wr", 32'(bus.waitrequest), 32'd1);
        tick();
        chk("rs_addr", bus.mem_address, 32'd0);
        chk("rs_miss", 32'(bus.miss_count), 32'd0);
        rst = 1'b0;
        bus.mem_readdata      = 32'h0000_0077;
        bus.mem_readdatavalid = 1'b1;
        tick();
        bus.mem_readdatavalid = 1'b0;
        bus.mem_readdata      = 32'h0;
        settle();
        chk("rs_idle_rd", 32'(bus.mem_read), 32'd0);
        bus.en = 1'b1;
        settle();
        chk("rs_inval_wr", 32'(bus.waitrequest), 32'd1);
        chk("rs_miss0", 32'(bus.miss_count), 32'd0);
        serve("rsr", BASE + 32'd1932, 32'h0000_00C3, 0, 2, 0);
        chk("rsr_pix", 32'(bus.pixel), 32'hC3);
        chk("rsr_miss", 32'(bus.miss_count), 32'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
